// File: rtl/maze_rx_framer.sv
// Parallel-port tile stream to tile-memory writes; write appears 2 clk edges after strobe first sampled high.
// No backpressure: the memory accepts every write, and strobes arriving faster than 3 clk high/low may be missed.
module maze_rx_framer #(
  parameter int ROWS           = 10,
  parameter int COLS           = 10,
  parameter int TIMEOUT_CYCLES = 2_516_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] port_in,
  output logic       wr_en,
  output logic [3:0] wr_row,
  output logic [3:0] wr_col,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       synced,
  output logic [7:0] frame_count,
  output logic [7:0] err_count
);

  localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0]  LAST_COL = 4'(COLS - 1);
  localparam logic [23:0] TIMEOUT  = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] IDLE_MAX = '1;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  s1_q, s2_q;
  logic        prev_q;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [23:0] idle_q, idle_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_row_q, wr_row_d;
  logic [3:0]  wr_col_q, wr_col_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        err_bump;

  logic        stb_edge;
  logic        new_frame;
  logic [7:0]  tile_byte;
  logic        at_origin;
  logic        at_last;
  logic        timeout_hit;

  assign stb_edge    = s2_q[8] & ~prev_q;
  assign new_frame   = s2_q[9];
  assign tile_byte   = s2_q[7:0];
  assign at_origin   = (row_q == 4'd0) && (col_q == 4'd0);
  assign at_last     = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign timeout_hit = (state_q == RECV) && !at_origin && (idle_q >= TIMEOUT);

  // prev follows s2 so the port's reset-time level never fakes a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= port_in;
      s2_q   <= s1_q;
      prev_q <= s2_q[8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      row_q         <= '0;
      col_q         <= '0;
      idle_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      idle_q        <= idle_d;
      wr_en_q       <= wr_en_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    idle_d        = (idle_q == IDLE_MAX) ? idle_q : idle_q + 24'd1;
    wr_en_d       = 1'b0;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    err_bump      = 1'b0;

    if (stb_edge) begin
      idle_d = '0;
      if (new_frame) begin
        // new_frame always re-anchors to (0,0); arriving mid-frame means the last frame was short
        err_bump  = (state_q == RECV) && !at_origin;
        state_d   = RECV;
        wr_en_d   = 1'b1;
        wr_row_d  = 4'd0;
        wr_col_d  = 4'd0;
        wr_data_d = tile_byte;
        row_d     = 4'd0;
        col_d     = 4'd1;
      end else if (state_q == RECV) begin
        wr_en_d   = 1'b1;
        wr_row_d  = row_q;
        wr_col_d  = col_q;
        wr_data_d = tile_byte;
        if (at_last) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          row_d         = 4'd0;
          col_d         = 4'd0;
        end else if (col_q == LAST_COL) begin
          row_d = row_q + 4'd1;
          col_d = 4'd0;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
    end else if (timeout_hit) begin
      state_d  = HUNT;
      row_d    = 4'd0;
      col_d    = 4'd0;
      err_bump = 1'b1;
    end

    if (err_bump && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign synced      = (state_q == RECV);
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/maze_rx_framer.md
# maze_rx_framer

Receives the maze tile stream from the Arduino over the 10-bit parallel port and turns it into tile-memory write commands. Internally it synchronises the port, detects strobe edges, keeps frame alignment and detects lost or short frames. It sits between the GPIO_1 parallel-port pins and the maze tile memory that the tile decoder reads. It replaces ad-hoc index arithmetic with explicit row/column counters and a recovery state machine.

## Interface

Parameters:
- ROWS, 10, tile rows per frame
- COLS, 10, tile columns per frame; frame length is ROWS*COLS bytes (100)
- TIMEOUT_CYCLES, 2_516_000, idle clk cycles (about 100 ms at 25.16 MHz) allowed between strobes mid-frame; must fit in 24 bits

Ports:
- clk, input, 1, pixel clock; all logic on its rising edge
- rst, input, 1, asynchronous, active-high reset
- port_in, input, 10, raw asynchronous parallel port: [9] new_frame, [8] strobe, [7:0] tile byte
- wr_en, output, 1, one-cycle tile-memory write strobe
- wr_row, output, 4, tile row of current write (0..ROWS-1)
- wr_col, output, 4, tile column of current write (0..COLS-1)
- wr_data, output, 8, tile byte to write
- frame_done, output, 1, one-cycle pulse when byte ROWS*COLS-1 of a frame is written
- synced, output, 1, high while in RECV state
- frame_count, output, 8, completed frames; wraps 255 -> 0
- err_count, output, 8, short-frame plus timeout errors; saturates at 255

## Operation

- Input path:
  - Two-flop synchroniser (s1, s2) on all 10 bits.
  - A third register (prev) holds s2[8].
  - Accepted strobe edge: s2[8]=1 and prev=0. Byte and new_frame are taken from s2 in the same cycle.
- Internal position: row/col counters, not division.
  - col increments; at COLS-1 it goes to 0 and row increments.
  - At (ROWS-1, COLS-1) both counters go to 0.
- State HUNT (reset state):
  - Edge with new_frame=0: byte discarded, no write.
  - Edge with new_frame=1: write byte at (0,0), position becomes (0,1), go to RECV.
- State RECV, edge with new_frame=0:
  - Write byte at current position, then advance.
  - If the position written was (ROWS-1, COLS-1): pulse frame_done, frame_count+1, position becomes (0,0), stay in RECV.
- State RECV, edge with new_frame=1:
  - Write at (0,0) and set position to (0,1).
  - If the position before the edge was not (0,0), this is a short frame: err_count+1.
- Timeout:
  - Idle counter clears on every accepted edge and otherwise increments, saturating.
  - Condition: RECV, position ≠ (0,0), and idle counter reaches TIMEOUT_CYCLES.
  - Action: go to HUNT, position becomes (0,0), err_count+1.
  - In RECV at (0,0) and in HUNT, no timeout is raised.
- err_count saturates: it holds at 255 and never wraps.
- All outputs are registered.

## Timing

- Reset (asynchronous, any cycle, including mid-frame):
  - State HUNT, position (0,0), idle counter 0, s1/s2/prev 0.
  - wr_en=0, wr_row=0, wr_col=0, wr_data=0, frame_done=0, synced=0, frame_count=0, err_count=0.
  - A partially received frame is abandoned; tiles already written stay in memory.
- Strobe held high across reset release is treated as one fresh rising edge, subject to the normal rules.
- Latency:
  - If port_in[8] is first sampled high at edge N, then wr_en, wr_row/col/data, frame_done and counter updates are valid from edge N+2 for exactly one cycle.
  - synced changes at the same edge as the state change.
- port_in[9] and port_in[7:0] must be stable from one cycle before through one cycle after the strobe's rising sample. The Arduino guarantees this by setting data before raising the strobe.
- Minimum strobe high and low time: 3 clk cycles each. Shorter pulses may be missed; this is not detected.
- wr_en never asserts on consecutive cycles.
- A strobe falling edge has no effect.

## Test plan

- Clean frame: reset, then 100 strobes, with new_frame=1 on byte 0 only and data = index.
  - Writes to (i/10, i%10) with data i.
  - frame_done pulses on the write of byte 99.
  - frame_count=1, err_count=0, synced=1.
- Back-to-back frames without new_frame on the second frame: 200 strobes, new_frame only on byte 0.
  - Second frame writes from (0,0).
  - frame_count=2, err_count=0.
- Short frame: new_frame frame of 40 bytes, then a new_frame frame of 100 bytes.
  - err_count=1.
  - The 41st byte is written to (0,0).
  - frame_count=1.
- Hunt discard: after reset, 5 strobes with new_frame=0.
  - No wr_en, synced=0.
  - The next new_frame byte is written to (0,0).
- Timeout, with TIMEOUT_CYCLES=50: 10 bytes, then 60 idle cycles.
  - synced falls, err_count=1.
  - A following non-new_frame strobe produces no write.
- Latency and reset:
  - port_in[8] first sampled high at edge N gives wr_en high only between edges N+2 and N+3.
  - Asserting rst at byte 57 zeroes all outputs immediately and the framer returns to HUNT.
